// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > taken branch > load-use.
// Define PIPELINE_PERF_CNT_EN to build the stall_cycles / flush_count performance counters.
module pipeline_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_use_hazard,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   input  logic        err_clr,
   input  logic        perf_clr,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_write,
   output logic        id_ex_flush,
   output logic        ex_mem_write,
   output logic        mem_wb_flush,
   output logic        mem_err,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   localparam int      CW       = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam bit      TO_EN    = (MEM_TIMEOUT != 0);
   localparam int      LAST_INT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAST_INT);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          mem_err_q, mem_err_d;
   logic          timeout;
   logic          freeze;

   assign timeout = TO_EN && (state_q == MEM_WAIT) && (wait_cnt_q == CNT_LAST);

   always_comb begin
      freeze = 1'b0;
      case (state_q)
         RUN:      freeze = mem_req && !mem_ready;
         MEM_WAIT: freeze = !mem_ready && !timeout;
         default:  freeze = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (freeze) begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end else begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      if (err_clr) mem_err_d = 1'b0;
      // A timeout in the same cycle as err_clr must not be lost.
      if (timeout && !mem_ready) mem_err_d = 1'b1;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      mem_wb_flush = 1'b0;
      if (freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use_hazard) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign mem_err = mem_err_q;

`ifdef PIPELINE_PERF_CNT_EN
   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (perf_clr) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (!pc_write && (stall_q != '1))
            stall_d = stall_q + 32'd1;
         if (!freeze && branch_taken && (flush_q != '1))
            flush_d = flush_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   logic unused_perf;
   assign unused_perf  = perf_clr;
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: vector table plus multi-cycle memory-wait sequences.
module tb_pipeline_stall_ctrl;

`ifdef PIPELINE_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, lu, br, mreq, mrdy, eclr, pclr;
   logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
   logic mem_err;
   logic [31:0] stall_cycles, flush_count;
   logic [6:0] outs;

   int checks = 0;
   int errors = 0;

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush}
   localparam logic [6:0] IDLE = 7'b1101010;
   localparam logic [6:0] FRZ  = 7'b0000001;
   localparam logic [6:0] BRF  = 7'b1111110;
   localparam logic [6:0] LUS  = 7'b0001110;

   assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};

   pipeline_stall_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .load_use_hazard(lu), .branch_taken(br), .mem_req(mreq), .mem_ready(mrdy),
      .err_clr(eclr), .perf_clr(pclr),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
      .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic       lu, br, mreq, mrdy;
      logic [6:0] exp;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic b, input logic q, input logic r);
      lu = l; br = b; mreq = q; mrdy = r;
      #1;
   endtask

   function automatic logic [31:0] pc(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic perf_clear();
      drive(0, 0, 0, 0);
      pclr = 1'b1;
      tick();
      pclr = 1'b0;
   endtask

   initial begin
      vt[0] = '{"idle",         0, 0, 0, 0, IDLE};
      vt[1] = '{"load_use",     1, 0, 0, 0, LUS};
      vt[2] = '{"branch",       0, 1, 0, 0, BRF};
      vt[3] = '{"branch_lu",    1, 1, 0, 0, BRF};
      vt[4] = '{"single_mem",   0, 0, 1, 1, IDLE};
      vt[5] = '{"single_mem_lu",1, 0, 1, 1, LUS};
      vt[6] = '{"mem_freeze",   0, 1, 1, 0, FRZ};
      vt[7] = '{"mem_release",  0, 1, 1, 1, BRF};
      vt[8] = '{"lu_after_rel", 1, 0, 0, 0, LUS};
      vt[9] = '{"idle_end",     0, 0, 0, 0, IDLE};

      rst = 1'b1; eclr = 1'b0; pclr = 1'b0;
      lu = 0; br = 0; mreq = 0; mrdy = 0;
      tick(); tick();
      rst = 1'b0;
      drive(0, 0, 0, 0);
      chk("reset_outs", 32'(outs), 32'(IDLE));
      chk("reset_mem_err", 32'(mem_err), 0);
      chk("reset_stall", stall_cycles, 0);
      chk("reset_flush", flush_count, 0);

      // Vector table, applied back to back; counters accumulate over it.
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].lu, vt[i].br, vt[i].mreq, vt[i].mrdy);
         chk(vt[i].nm, 32'(outs), 32'(vt[i].exp));
         tick();
      end
      chk("table_stall", stall_cycles, pc(4));
      chk("table_flush", flush_count, pc(3));

      perf_clear();
      chk("perf_clr_stall", stall_cycles, 0);
      chk("perf_clr_flush", flush_count, 0);

      drive(1, 0, 0, 0);
      tick();
      chk("lu_stall_cnt", stall_cycles, pc(1));
      perf_clear();
      drive(1, 1, 0, 0);
      tick();
      chk("br_lu_flush_cnt", flush_count, pc(1));
      chk("br_lu_stall_cnt", stall_cycles, pc(0));

      // Three frozen cycles with a branch held, released on the 4th.
      perf_clear();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0);
         chk($sformatf("freeze_%0d", i), 32'(outs), 32'(FRZ));
         tick();
      end
      drive(0, 1, 1, 1);
      chk("freeze_release", 32'(outs), 32'(BRF));
      tick();
      drive(0, 0, 0, 0);
      chk("freeze_after", 32'(outs), 32'(IDLE));
      chk("freeze_stall_cnt", stall_cycles, pc(3));
      chk("freeze_flush_cnt", flush_count, pc(1));
      chk("freeze_no_err", 32'(mem_err), 0);

      // Timeout: 4 frozen cycles, forced release on the 5th.
      perf_clear();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0);
         chk($sformatf("to_freeze_%0d", i), 32'(outs), 32'(FRZ));
         tick();
      end
      chk("to_err_before", 32'(mem_err), 0);
      drive(0, 0, 1, 0);
      chk("to_release", 32'(outs), 32'(IDLE));
      tick();
      drive(0, 0, 0, 0);
      chk("to_err_set", 32'(mem_err), 1);
      chk("to_after", 32'(outs), 32'(IDLE));
      chk("to_stall_cnt", stall_cycles, pc(4));
      eclr = 1'b1;
      tick();
      eclr = 1'b0;
      chk("err_clr", 32'(mem_err), 0);

      // err_clr held through a timeout: the set must win.
      eclr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1, 0);
         tick();
      end
      eclr = 1'b0;
      drive(0, 0, 0, 0);
      chk("err_set_wins", 32'(mem_err), 1);

      // perf_clr beats a simultaneous increment.
      drive(1, 0, 0, 0);
      pclr = 1'b1;
      tick();
      pclr = 1'b0;
      drive(0, 0, 0, 0);
      chk("perf_clr_prio", stall_cycles, 0);

      // Reset in the 2nd MEM_WAIT cycle with mem_req low.
      drive(0, 0, 1, 0);
      tick();
      tick();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      chk("rst_cycle_frozen", 32'(outs), 32'(FRZ));
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0);
      chk("rst_wait_outs", 32'(outs), 32'(IDLE));
      chk("rst_wait_err", 32'(mem_err), 0);
      chk("rst_wait_stall", stall_cycles, 0);
      tick();
      chk("rst_wait_stays_run", 32'(outs), 32'(IDLE));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges three hazard sources into one consistent set of pipeline-register write-enables and flushes, applied in a fixed priority:

- multi-cycle data-memory wait (highest);
- taken branch resolved in EX;
- load-use hazard reported by the hazard detection logic (lowest).

It also owns a memory-wait timeout with a sticky error flag and optional performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max MEM_WAIT cycles before forced release; 0 disables the timeout.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_use_hazard  input  1  load-use hazard between ID/EX and IF/ID.
- branch_taken  input  1  EX-stage branch/jump redirect.
- mem_req  input  1  valid load/store in MEM stage.
- mem_ready  input  1  data memory completes the MEM-stage access this cycle.
- err_clr  input  1  clears mem_err.
- perf_clr  input  1  clears performance counters.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID write enable.
- if_id_flush  output  1  IF/ID becomes bubble.
- id_ex_write  output  1  ID/EX write enable.
- id_ex_flush  output  1  ID/EX becomes bubble.
- ex_mem_write  output  1  EX/MEM write enable.
- mem_wb_flush  output  1  MEM/WB receives bubble.
- mem_err  output  1  sticky: a memory wait timed out.
- stall_cycles  output  32  cycles with pc_write=0.
- flush_count  output  32  taken-branch flushes.

## Operation
- State register: RUN, MEM_WAIT. Wait counter wait_cnt has width $clog2(MEM_TIMEOUT+1), minimum 1.
- freeze = (RUN && mem_req && !mem_ready) || (MEM_WAIT && !mem_ready && !timeout).
- timeout = MEM_TIMEOUT != 0 && wait_cnt == MEM_TIMEOUT-1.
- Transitions:
  - RUN -> MEM_WAIT on mem_req && !mem_ready; wait_cnt <= 0.
  - MEM_WAIT stays while freeze; wait_cnt increments.
  - MEM_WAIT -> RUN on mem_ready or timeout.
  - When timeout && !mem_ready, mem_err <= 1.
- Output priority (combinational from state and inputs):
  - freeze: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_flush=1, other flushes 0. branch_taken and load_use_hazard are ignored; they stay asserted from the frozen stages and are acted on at release.
  - else branch_taken: all writes 1, if_id_flush=id_ex_flush=1, mem_wb_flush=0.
  - else load_use_hazard: pc_write=if_id_write=0, id_ex_flush=1, id_ex_write=ex_mem_write=1.
  - else: all writes 1, all flushes 0.
- mem_err: set by timeout, cleared by err_clr or rst. Set wins over simultaneous err_clr.

## Timing
- Control outputs are zero-latency (same cycle as their inputs). State, wait_cnt, mem_err and counters update at the next edge.
- Reset (after the rst edge): state RUN, wait_cnt 0, mem_err 0, counters 0. With all inputs low, outputs are pc_write=if_id_write=id_ex_write=ex_mem_write=1 and all flushes 0.
- rst during MEM_WAIT: the next cycle is RUN, and freeze holds only if mem_req && !mem_ready.
- mem_ready already high in the request cycle: no freeze and no state change (single-cycle access).
- Timeout cycle: freeze=0, so the pipeline advances. The stale access is discarded by the memory side.
- Back-to-back accesses: RUN re-evaluates mem_req on the release-following cycle.

## Configuration
- PIPELINE_PERF_CNT_EN defined: counters are implemented.
  - stall_cycles increments each cycle pc_write=0.
  - flush_count increments each cycle branch_taken is acted on (not frozen).
  - Both saturate at 0xFFFFFFFF.
  - perf_clr zeroes them and takes priority over increment.
- Not defined: stall_cycles and flush_count are tied to 0 and perf_clr is ignored. No counter registers are synthesized.

## Test plan
- Reset, then idle inputs -> all writes 1, flushes 0, mem_err 0, counters 0.
- load_use_hazard=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles=1.
- branch_taken=1 and load_use_hazard=1 together -> if_id_flush=id_ex_flush=1, pc_write=1; flush_count=1, stall_cycles=0.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with branch_taken=1 held -> freeze for 3 cycles with mem_wb_flush=1, branch flush on the 4th cycle; stall_cycles=3, flush_count=1.
- MEM_TIMEOUT=4 with mem_ready never asserted -> 4 frozen cycles (RUN plus 3 MEM_WAIT), release on the 5th, mem_err=1 from the next cycle. err_clr then drops it to 0.
- Assert rst in the 2nd MEM_WAIT cycle with mem_req=0 -> RUN, outputs back to idle values the next cycle, wait_cnt 0.
